// File: rtl/core_rrv_exe_mdu.sv
// RV32M multiply/divide execute unit beside the Q102H ALU.
// Optional divide result cache: define CORE_RRV_MDU_DIV_CACHE_EN.
module core_rrv_exe_mdu #(
  parameter int XLEN       = 32,
  parameter int MUL_LAT    = 2,
  parameter int FWD_STAGES = 3
) (
  input  logic                                 Clock,
  input  logic                                 Rst,
  input  logic                                 ValidQ102H,
  input  logic                                 MdEnQ102H,
  input  logic [2:0]                           MdOpQ102H,
  input  logic [4:0]                           RegSrc1Q102H,
  input  logic [4:0]                           RegSrc2Q102H,
  input  logic [XLEN-1:0]                      PreRegRdData1Q102H,
  input  logic [XLEN-1:0]                      PreRegRdData2Q102H,
  input  logic [FWD_STAGES-1:0][4:0]           FwdRegDst,
  input  logic [FWD_STAGES-1:0]                FwdWrEn,
  input  logic [FWD_STAGES-1:0][XLEN-1:0]      FwdData,
  input  logic                                 FlushQ102H,
  input  logic                                 ReadyQ103H,
  output logic                                 StallQ102H,
  output logic                                 MdValidQ103H,
  output logic [XLEN-1:0]                      MdResultQ103H
);

  localparam int CW = $clog2(XLEN + MUL_LAT + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] out_q, out_d;

  logic            stall;
  logic            issue;
  logic [XLEN-1:0] op1, op2;
  logic            sgn;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] abs1, abs2;

  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     rem_sh, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nx, quo_nx;
  logic [XLEN-1:0]   q_fin, r_fin;

  logic            c_hit;
  logic [XLEN-1:0] c_res;

  // Lowest stage index is youngest, so it is applied last and wins.
  always_comb begin
    op1 = PreRegRdData1Q102H;
    op2 = PreRegRdData2Q102H;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (FwdWrEn[k] && FwdRegDst[k] == RegSrc1Q102H) op1 = FwdData[k];
      if (FwdWrEn[k] && FwdRegDst[k] == RegSrc2Q102H) op2 = FwdData[k];
    end
    if (RegSrc1Q102H == 5'd0) op1 = '0;
    if (RegSrc2Q102H == 5'd0) op2 = '0;
  end

  assign issue    = ValidQ102H & MdEnQ102H & ~FlushQ102H;
  assign sgn      = ~MdOpQ102H[0];
  assign div_zero = (op2 == '0);
  assign div_ovf  = sgn && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  assign abs1     = (sgn && op1[XLEN-1]) ? ('0 - op1) : op1;
  assign abs2     = (sgn && op2[XLEN-1]) ? ('0 - op2) : op2;

  // Operands widened so one unsigned product serves all MULH variants.
  always_comb begin
    ma = {{XLEN{(op_q[1:0] != 2'b11) & a_q[XLEN-1]}}, a_q};
    mb = {{XLEN{(op_q[1:0] == 2'b01) & b_q[XLEN-1]}}, b_q};
    prod = ma * mb;
    mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = ~diff[XLEN];
    rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ge};
    q_fin  = negq_q ? ('0 - quo_nx) : quo_nx;
    r_fin  = negr_q ? ('0 - rem_nx) : rem_nx;
  end

`ifdef CORE_RRV_MDU_DIV_CACHE_EN
  logic            c_vld_q, c_vld_d;
  logic            c_sgn_q, c_sgn_d;
  logic [XLEN-1:0] c_a_q, c_a_d;
  logic [XLEN-1:0] c_b_q, c_b_d;
  logic [XLEN-1:0] c_q_q, c_q_d;
  logic [XLEN-1:0] c_r_q, c_r_d;

  always_comb begin
    c_vld_d = c_vld_q;
    c_sgn_d = c_sgn_q;
    c_a_d   = c_a_q;
    c_b_d   = c_b_q;
    c_q_d   = c_q_q;
    c_r_d   = c_r_q;
    if (FlushQ102H && state_q != S_IDLE && op_q[2]) begin
      c_vld_d = 1'b0;
    end else if (state_q == S_DIV && cnt_q == DIV_LAST) begin
      c_vld_d = 1'b1;
      c_sgn_d = ~op_q[0];
      c_a_d   = a_q;
      c_b_d   = b_q;
      c_q_d   = q_fin;
      c_r_d   = r_fin;
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_q_q   <= '0;
      c_r_q   <= '0;
    end else begin
      c_vld_q <= c_vld_d;
      c_sgn_q <= c_sgn_d;
      c_a_q   <= c_a_d;
      c_b_q   <= c_b_d;
      c_q_q   <= c_q_d;
      c_r_q   <= c_r_d;
    end
  end

  assign c_hit = c_vld_q && (c_a_q == op1) && (c_b_q == op2) && (c_sgn_q == sgn);
  assign c_res = MdOpQ102H[1] ? c_r_q : c_q_q;
`else
  assign c_hit = 1'b0;
  assign c_res = '0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    out_d   = out_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = issue;
        if (issue) begin
          op_d   = MdOpQ102H;
          a_d    = op1;
          b_d    = op2;
          quo_d  = abs1;
          dvs_d  = abs2;
          rem_d  = '0;
          cnt_d  = '0;
          negq_d = sgn & (op1[XLEN-1] ^ op2[XLEN-1]);
          negr_d = sgn & op1[XLEN-1];
          if (!MdOpQ102H[2]) begin
            state_d = S_MUL;
          end else if (div_zero) begin
            state_d = S_DONE;
            res_d   = MdOpQ102H[1] ? op1 : '1;
          end else if (div_ovf) begin
            state_d = S_DONE;
            res_d   = MdOpQ102H[1] ? '0 : op1;
          end else if (c_hit) begin
            state_d = S_DONE;
            res_d   = c_res;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          res_d   = mul_res;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        quo_d = quo_nx;
        rem_d = rem_nx;
        if (cnt_q == DIV_LAST) begin
          state_d = S_DONE;
          res_d   = op_q[1] ? r_fin : q_fin;
        end
      end
      S_DONE: begin
        stall = ~ReadyQ103H;
        if (ReadyQ103H) begin
          vld_d   = 1'b1;
          out_d   = res_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush kills the op outright, even one ready to hand off.
    if (FlushQ102H && state_q != S_IDLE) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
      out_d   = out_q;
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
    end
  end

  assign StallQ102H    = stall;
  assign MdValidQ103H  = vld_q;
  assign MdResultQ103H = out_q;

endmodule
